// File: rtl/capture_frame_serializer.sv
// Trigger-started capture buffer that drains a framed, width-reduced beat stream:
// signature word, word-count word, then the captured words, MSB beat first.
module capture_frame_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned DEPTH      = 256,
  parameter logic [31:0] SIGNATURE  = 32'hFF807F00
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  input  logic [DATA_WIDTH-1:0]    DataIn,
  input  logic                     DataInValid,
  input  logic                     TriggerIn,
  input  logic                     Abort,
  input  logic [$clog2(DEPTH):0]   FrameLength,
  output logic [OUT_WIDTH-1:0]     OutData,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic                     Armed,
  output logic [1:0]               State,
  output logic                     Overrun
);

  localparam int unsigned RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned IW    = AW + 2;
  localparam logic [DATA_WIDTH-1:0] SIG_WORD  = DATA_WIDTH'(SIGNATURE);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(RATIO - 1);
  localparam logic [AW:0]           DEPTH_LEN = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_DRAIN   = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_trig_q;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [AW:0]           r_len;
  logic [IW-1:0]         r_word_idx;
  logic [BW-1:0]         r_beat;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_out_valid;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_edge;
  logic                  w_wr;
  logic                  w_cap_done;
  logic                  w_accept;
  logic                  w_word_done;
  logic                  w_frame_done;
  logic [AW:0]           w_count_inc;
  logic [IW-1:0]         w_last_idx;

  assign w_edge      = TriggerIn & ~r_trig_q;
  assign w_count_inc = r_count + (AW+1)'(1);
  assign w_last_idx  = IW'(r_count) + IW'(1);

  // State register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) r_state <= ST_ARMED;
    else         r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_wr         = 1'b0;
    w_cap_done   = 1'b0;
    w_accept     = 1'b0;
    w_word_done  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_ARMED: begin
        if (w_edge) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_wr       = DataInValid;
        w_cap_done = Abort | (DataInValid & (w_count_inc == r_len));
        if (w_cap_done) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_accept     = r_out_valid & OutReady;
        w_word_done  = w_accept & (r_beat == LAST_BEAT);
        w_frame_done = w_word_done & (r_word_idx == w_last_idx);
        if (w_frame_done) w_state_nxt = ST_ARMED;
      end
      default: w_state_nxt = ST_ARMED;
    endcase
  end

  // Capture bookkeeping and output serializer; the buffer is read asynchronously so
  // the next word is already available on the last beat of the current one.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_trig_q    <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_beat      <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_trig_q <= TriggerIn;
      if (DataInValid && (r_state == ST_DRAIN)) r_overrun <= 1'b1;
      case (r_state)
        ST_ARMED: begin
          if (w_edge) begin
            r_len    <= ((FrameLength == '0) || (FrameLength > DEPTH_LEN)) ? DEPTH_LEN : FrameLength;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
          end
        end
        ST_CAPTURE: begin
          if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count  <= w_count_inc;
          end
          if (w_cap_done) begin
            r_shift     <= SIG_WORD;
            r_out_valid <= 1'b1;
            r_beat      <= '0;
            r_word_idx  <= '0;
            r_rd_ptr    <= '0;
          end
        end
        ST_DRAIN: begin
          if (w_accept && !w_word_done) begin
            r_shift <= r_shift << OUT_WIDTH;
            r_beat  <= r_beat + BW'(1);
          end else if (w_frame_done) begin
            r_out_valid <= 1'b0;
            r_shift     <= '0;
            r_beat      <= '0;
            r_word_idx  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
          end else if (w_word_done) begin
            r_beat     <= '0;
            r_word_idx <= r_word_idx + IW'(1);
            if (r_word_idx == '0) begin
              r_shift <= DATA_WIDTH'(r_count);
            end else begin
              r_shift  <= r_mem[r_rd_ptr];
              r_rd_ptr <= r_rd_ptr + AW'(1);
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_shift     <= '0;
          r_wr_ptr    <= '0;
          r_rd_ptr    <= '0;
        end
      endcase
    end
  end

  // Capture buffer storage
  always_ff @(posedge Clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= DataIn;
  end

  assign OutData  = r_shift[DATA_WIDTH-1 -: OUT_WIDTH];
  assign OutValid = r_out_valid;
  assign Armed    = (r_state == ST_ARMED);
  assign State    = r_state;
  assign Overrun  = r_overrun;

endmodule

// File: tb/tb_capture_frame_serializer.sv
// Self-checking bench: table of frames, byte scoreboard, plus reset/trigger sequences.
module tb_capture_frame_serializer;

  localparam int unsigned DW    = 32;
  localparam int unsigned OW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          Clock;
  logic          ResetN;
  logic [DW-1:0] DataIn;
  logic          DataInValid;
  logic          TriggerIn;
  logic          Abort;
  logic [AW:0]   FrameLength;
  logic [OW-1:0] OutData;
  logic          OutValid;
  logic          OutReady;
  logic          Armed;
  logic [1:0]    State;
  logic          Overrun;

  capture_frame_serializer #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .SIGNATURE(32'hFF807F00)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .DataIn(DataIn), .DataInValid(DataInValid),
    .TriggerIn(TriggerIn), .Abort(Abort), .FrameLength(FrameLength),
    .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .Armed(Armed), .State(State), .Overrun(Overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int          len;
    int          nwords;
    bit          abort_last;
    bit          abort_only;
    int          ready_mode;
    bit          pulse;
    logic [31:0] base;
    int          exp_count;
    bit          exp_ovr;
  } vec_t;

  vec_t         vecs [8];
  logic [7:0]   sb [$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           ready_mode = 0;
  int           rcnt = 0;
  int           drain_cycles = 0;
  logic         prev_stall = 1'b0;
  logic [7:0]   prev_data = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) sb.push_back(w[31-8*b -: 8]);
  endtask

  // OutReady pattern generator: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge Clock); #1;
      case (ready_mode)
        1:       begin OutReady = (rcnt % 3 == 0); rcnt++; end
        2:       OutReady = 1'($urandom_range(0, 1));
        default: OutReady = 1'b1;
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every accepted beat
  always @(negedge Clock) begin
    if (!ResetN) begin
      prev_stall = 1'b0;
    end else begin
      if (State == 2'b10) begin
        drain_cycles++;
        chk("valid_in_drain", 64'(OutValid), 64'd1);
      end
      if (prev_stall) begin
        chk("stall_valid_hold", 64'(OutValid), 64'd1);
        chk("stall_data_hold", 64'(OutData), 64'(prev_data));
      end
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(OutData), 64'hDEAD);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          chk("beat", 64'(OutData), 64'(e));
        end
      end
      prev_stall = OutValid && !OutReady;
      prev_data  = OutData;
    end
  end

  task automatic drive_frame(input int k, output int drain_start);
    vec_t v;
    int   t;
    v = vecs[k];
    t = 0;
    while (State != 2'b00 && t < 500) begin @(posedge Clock); #1; t++; end
    chk("armed_before_frame", 64'(State), 64'd0);
    @(posedge Clock); #1;
    ready_mode  = v.ready_mode;
    FrameLength = 5'(v.len);
    TriggerIn   = 1'b1;
    DataInValid = 1'b0;
    drain_start = drain_cycles;
    push_word(32'hFF807F00);
    push_word(32'(v.exp_count));
    for (int i = 0; i < v.exp_count; i++) push_word(v.base + 32'(i) * 32'h44444444);
    @(posedge Clock); #1;
    TriggerIn = 1'b0;
    if (v.abort_only) begin
      Abort = 1'b1;
      @(posedge Clock); #1;
      Abort = 1'b0;
    end
    for (int i = 0; i < v.nwords; i++) begin
      DataInValid = 1'b1;
      DataIn      = v.base + 32'(i) * 32'h44444444;
      Abort       = v.abort_last && (i == v.nwords - 1);
      if (v.pulse) TriggerIn = (i % 2 == 1);
      @(posedge Clock); #1;
    end
    DataInValid = 1'b0;
    Abort       = 1'b0;
    TriggerIn   = 1'b0;
  endtask

  task automatic finish_frame(input int k, input bit exp_ovr, input int drain_start);
    vec_t v;
    int   t;
    v = vecs[k];
    t = 0;
    while (t < 3000) begin
      @(posedge Clock); #1;
      if (State == 2'b00 && sb.size() == 0) break;
      TriggerIn = (v.pulse && State == 2'b10) ? ~TriggerIn : 1'b0;
      t++;
    end
    TriggerIn = 1'b0;
    chk("frame_timeout", 64'(t < 3000), 64'd1);
    chk("left_beats", 64'(sb.size()), 64'd0);
    sb.delete();
    chk("end_state", 64'(State), 64'd0);
    chk("end_armed", 64'(Armed), 64'd1);
    chk("end_outvalid", 64'(OutValid), 64'd0);
    chk("overrun", 64'(Overrun), 64'(exp_ovr));
    if (v.ready_mode == 0)
      chk("drain_cycles", 64'(drain_cycles - drain_start), 64'((2 + v.exp_count) * 4));
    if (v.pulse) begin
      repeat (4) @(posedge Clock);
      #1;
      chk("no_retrigger", 64'(State), 64'd0);
    end
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int ds;
    //            len nw  abL abO rdy pul base           cnt ovr
    vecs[0] = '{3,  3,  1'b0, 1'b0, 0, 1'b0, 32'h11223344, 3,  1'b0};
    vecs[1] = '{3,  3,  1'b0, 1'b0, 1, 1'b0, 32'h11223344, 3,  1'b0};
    vecs[2] = '{8,  3,  1'b1, 1'b0, 0, 1'b0, 32'hA0000001, 3,  1'b0};
    vecs[3] = '{8,  0,  1'b0, 1'b1, 2, 1'b0, 32'h00000000, 0,  1'b0};
    vecs[4] = '{1,  1,  1'b0, 1'b0, 2, 1'b0, 32'h0BADF00D, 1,  1'b0};
    vecs[5] = '{0,  20, 1'b0, 1'b0, 0, 1'b0, 32'h01020304, 16, 1'b1};
    vecs[6] = '{20, 20, 1'b0, 1'b0, 1, 1'b0, 32'hF0E0D0C0, 16, 1'b1};
    vecs[7] = '{3,  3,  1'b0, 1'b0, 2, 1'b1, 32'h11223344, 3,  1'b1};

    ResetN = 1'b0; TriggerIn = 1'b1; DataInValid = 1'b0; DataIn = '0;
    Abort = 1'b0; FrameLength = '0;
    #1;
    chk("rst_state", 64'(State), 64'd0);
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_outdata", 64'(OutData), 64'd0);
    chk("rst_overrun", 64'(Overrun), 64'd0);
    chk("rst_armed", 64'(Armed), 64'd1);
    repeat (3) @(posedge Clock);
    #1 ResetN = 1'b1;
    repeat (5) @(posedge Clock);
    #1;
    chk("held_trigger_no_start", 64'(State), 64'd0);
    TriggerIn = 1'b0;
    @(posedge Clock); #1;

    for (int k = 0; k < 8; k++) begin
      drive_frame(k, ds);
      finish_frame(k, vecs[k].exp_ovr, ds);
    end

    // Asynchronous reset in the middle of a drain
    drive_frame(1, ds);
    for (int t = 0; t < 200 && State != 2'b10; t++) begin @(posedge Clock); #1; end
    chk("reached_drain", 64'(State), 64'd2);
    repeat (5) @(posedge Clock);
    #3 ResetN = 1'b0;
    #1;
    chk("async_rst_outvalid", 64'(OutValid), 64'd0);
    chk("async_rst_state", 64'(State), 64'd0);
    chk("async_rst_overrun", 64'(Overrun), 64'd0);
    sb.delete();
    repeat (2) @(posedge Clock);
    #1 ResetN = 1'b1;
    drive_frame(0, ds);
    finish_frame(0, 1'b0, ds);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_frame_serializer.md
Name: capture_frame_serializer

Overview:
- Parametrised successor to the fixed 32-to-8 capture/store block.
- Single-clock design. Armed by default. A rising edge on TriggerIn starts capture of up to FrameLength words of DataIn into an internal buffer.
- After capture, it drains a framed byte stream: signature word, word-count word, then the captured data.
- Sits between the ADC/acquisition front end and the byte-wide host/UART/USB transmit path.

Parameters:
- DATA_WIDTH, 32, width of each captured input word; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, width of each output beat.
- DEPTH, 256, buffer capacity in words; must be a power of two, at least 2.
- SIGNATURE, 32'hFF807F00, start-of-frame word. It is zero-extended or truncated to DATA_WIDTH.
- Derived: RATIO = DATA_WIDTH/OUT_WIDTH; AW = log2(DEPTH).

Ports:
- Clock, input, 1, the only clock.
- ResetN, input, 1, asynchronous active-low reset.
- DataIn, input, DATA_WIDTH, sample word.
- DataInValid, input, 1, DataIn is valid this cycle.
- TriggerIn, input, 1, level input; its rising edge starts capture.
- Abort, input, 1, ends CAPTURE early.
- FrameLength, input, AW+1, words to capture; sampled on the trigger edge.
- OutData, output, OUT_WIDTH, serialized beat.
- OutValid, output, 1, OutData is valid.
- OutReady, input, 1, downstream accepts the beat.
- Armed, output, 1, high in ARMED.
- State, output, 2, current state code.
- Overrun, output, 1, sticky flag for DataInValid seen while the buffer is full or in DRAIN.

Behaviour:
- Reset (asynchronous, ResetN=0) takes effect immediately:
  - State=ARMED(00); OutValid=0; OutData=0; Overrun=0.
  - Write pointer, read pointer, count and beat counter are 0.
  - Trigger history register is 1, so a TriggerIn held high through reset does not trigger.
- Reset mid-capture or mid-drain discards all buffered data. No partial frame is emitted.
- States: ARMED=00, CAPTURE=01, DRAIN=10. Code 11 is unused and must recover to ARMED on the next clock.
- Trigger edge detection: trig_q <= TriggerIn each cycle; edge = TriggerIn & ~trig_q.
- ARMED -> CAPTURE on an edge:
  - Latch len = FrameLength; 0 or any value above DEPTH means DEPTH.
  - Clear the word count.
  - The trigger cycle's DataIn is not captured.
  - Edges in CAPTURE or DRAIN are ignored.
- CAPTURE:
  - Each cycle with DataInValid=1 writes DataIn at wr_ptr and increments wr_ptr and count.
  - -> DRAIN on the cycle that count reaches len, i.e. the len-th word is written on the transition cycle.
  - Abort=1 -> DRAIN with the current count. A DataInValid word in the same cycle as Abort is still written.
  - Abort outside CAPTURE has no effect.
- DRAIN emits (2+count) words as RATIO beats each, MSB beat first:
  - Word 0 = SIGNATURE.
  - Word 1 = count, zero-extended to DATA_WIDTH.
  - Words 2.. = captured data, oldest first.
  - count=0 emits the header only (2*RATIO beats).
- DRAIN latency and throughput:
  - OutValid rises on the first cycle in DRAIN.
  - With OutReady held high there are no bubbles: exactly one beat per cycle, including at word boundaries (buffer read must be prefetched).
- Handshake:
  - A beat transfers on a cycle with OutValid & OutReady.
  - While OutValid=1 and OutReady=0, OutData must stay stable.
  - OutValid never drops until the beat is accepted.
- Last beat accepted -> ARMED on the next cycle:
  - OutValid=0 in ARMED.
  - Pointers reset to 0.
  - Overrun is not cleared; only reset clears it.
- Overrun is set by DataInValid=1 in DRAIN. Data in ARMED is silently ignored.
- Armed = (State==ARMED).

Test Plan:
- Basic frame (DATA_WIDTH=32, OUT_WIDTH=8, DEPTH=16):
  - Stimulus: FrameLength=3; trigger edge; DataIn 11223344, 55667788, 99AABBCC on consecutive valid cycles; OutReady=1.
  - Required: OutData FF 80 7F 00 00 00 00 03 11 22 33 44 55 66 77 88 99 AA BB CC; 20 beats on consecutive cycles; then ARMED.
- Backpressure:
  - Stimulus: same frame; OutReady toggles 1,0,0,1,...
  - Required: identical byte sequence; OutData stable during stalls; no beat lost or duplicated.
- Clamp and full:
  - Stimulus: FrameLength=0, then FrameLength=20; supply 20 valid words each time.
  - Required: count word = 00000010 and 16 data words each time; words 17-20 set Overrun=1.
- Abort:
  - Stimulus: FrameLength=8; 2 valid words; Abort with a 3rd valid word in the same cycle.
  - Required: count=3. Separately, Abort before any word -> header only, count word 00000000.
- Trigger rules:
  - Stimulus: TriggerIn held high through reset release; pulses during CAPTURE and DRAIN.
  - Required: no capture starts; mid-frame pulses ignored; a new edge after return to ARMED starts the next frame.
- Async reset:
  - Stimulus: assert ResetN=0 mid-DRAIN between clock edges.
  - Required: OutValid=0 and State=00 immediately; after release, the next trigger produces a clean frame starting FF 80 7F 00.
